// File: rtl/bp_be_issue_queue_pkg.sv
// Shared types for the BE issue queue: FE exception codes and the issue packet layout.
package bp_be_issue_queue_pkg;

    localparam int vaddr_width_gp = 39;
    localparam int instr_width_gp = 32;

    typedef enum logic [1:0] {
        e_instr_misaligned   = 2'd0,
        e_itlb_miss          = 2'd1,
        e_instr_page_fault   = 2'd2,
        e_instr_access_fault = 2'd3
    } bp_fe_exception_code_e;

    typedef struct packed {
        logic [vaddr_width_gp-1:0] pc;
        logic [instr_width_gp-1:0] instr;
        logic                      exc_not_instr;
        bp_fe_exception_code_e     exc;
    } bp_be_issue_pkt_s;

    localparam int issue_pkt_width_gp = $bits(bp_be_issue_pkt_s);

    function automatic logic is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/bp_be_issue_queue_if.sv
// FE-enqueue and decoder-issue handshake bundle; slave is the queue, master drives it.
interface bp_be_issue_queue_if;
    import bp_be_issue_queue_pkg::*;

    logic                      fe_v_i;
    logic                      fe_ready_o;
    logic [vaddr_width_gp-1:0] fe_pc_i;
    logic [instr_width_gp-1:0] fe_instr_i;
    logic                      fe_exc_not_instr_i;
    bp_fe_exception_code_e     fe_exc_i;
    logic                      issue_v_o;
    bp_be_issue_pkt_s          issue_pkt_o;
    logic                      issue_yumi_i;

    modport slave (
        input  fe_v_i, fe_pc_i, fe_instr_i, fe_exc_not_instr_i, fe_exc_i, issue_yumi_i,
        output fe_ready_o, issue_v_o, issue_pkt_o
    );

    modport master (
        output fe_v_i, fe_pc_i, fe_instr_i, fe_exc_not_instr_i, fe_exc_i, issue_yumi_i,
        input  fe_ready_o, issue_v_o, issue_pkt_o
    );

endinterface

// File: rtl/bp_be_issue_queue_mem.sv
// Entry storage: one synchronous write port, one asynchronous read port, no reset.
module bp_be_issue_queue_mem
    import bp_be_issue_queue_pkg::*;
#(
    parameter  int els_p        = 8,
    localparam int idx_width_lp = $clog2(els_p)
) (
    input  logic                    clk_i,
    input  logic                    w_v_i,
    input  logic [idx_width_lp-1:0] w_addr_i,
    input  bp_be_issue_pkt_s        w_pkt_i,
    input  logic [idx_width_lp-1:0] r_addr_i,
    output bp_be_issue_pkt_s        r_pkt_o
);

    bp_be_issue_pkt_s mem_d [els_p];
    bp_be_issue_pkt_s mem_q [els_p];

    always_comb begin
        mem_d = mem_q;
        if (w_v_i) begin
            mem_d[w_addr_i] = w_pkt_i;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assign r_pkt_o = mem_q[r_addr_i];

endmodule

// File: rtl/bp_be_issue_queue.sv
// Replayable issue queue: entries stay resident until committed so a roll-back can
// re-issue them from the commit pointer without refetching.
module bp_be_issue_queue
    import bp_be_issue_queue_pkg::*;
#(
    parameter  int els_p         = 8,
    parameter  int vaddr_width_p = vaddr_width_gp,
    localparam int idx_width_lp  = $clog2(els_p),
    localparam int ptr_width_lp  = idx_width_lp + 1
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    bp_be_issue_queue_if.slave      io,
    input  logic                    commit_v_i,
    input  logic                    roll_v_i,
    input  logic                    clr_v_i,
    output logic                    empty_o
);

    logic [ptr_width_lp-1:0] wptr_q, wptr_d;
    logic [ptr_width_lp-1:0] rptr_q, rptr_d;
    logic [ptr_width_lp-1:0] cptr_q, cptr_d;
    logic [ptr_width_lp-1:0] cptr_commit;
    logic                    full;
    logic                    accept;
    logic                    issue_v;
    bp_be_issue_pkt_s        fe_pkt;
    bp_be_issue_pkt_s        rd_pkt;

    // Same index with opposite wrap bits means every slot holds an uncommitted entry.
    assign full   = (wptr_q[idx_width_lp-1:0] == cptr_q[idx_width_lp-1:0])
                 && (wptr_q[ptr_width_lp-1] != cptr_q[ptr_width_lp-1]);
    assign accept  = io.fe_v_i & ~full;
    assign issue_v = (rptr_q != wptr_q);
    assign empty_o = (wptr_q == cptr_q);

    assign io.fe_ready_o  = ~full;
    assign io.issue_v_o   = issue_v;
    assign io.issue_pkt_o = issue_v ? rd_pkt : '0;

    assign fe_pkt = '{pc:            io.fe_pc_i,
                      instr:         io.fe_instr_i,
                      exc_not_instr: io.fe_exc_not_instr_i,
                      exc:           io.fe_exc_i};

    bp_be_issue_queue_mem #(.els_p(els_p)) mem (
        .clk_i    (clk_i),
        .w_v_i    (accept & ~clr_v_i),
        .w_addr_i (wptr_q[idx_width_lp-1:0]),
        .w_pkt_i  (fe_pkt),
        .r_addr_i (rptr_q[idx_width_lp-1:0]),
        .r_pkt_o  (rd_pkt)
    );

    assign cptr_commit = cptr_q + ptr_width_lp'(commit_v_i);

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cptr_d = cptr_q;
        if (clr_v_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cptr_d = '0;
        end else if (roll_v_i) begin
            wptr_d = wptr_q + ptr_width_lp'(accept);
            cptr_d = cptr_commit;
            rptr_d = cptr_commit;
        end else begin
            wptr_d = wptr_q + ptr_width_lp'(accept);
            rptr_d = rptr_q + ptr_width_lp'(io.issue_yumi_i);
            cptr_d = cptr_commit;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cptr_q <= cptr_d;
        end
    end

    // Protocol and parameter checks; a clear discards everything else that cycle.
    always_ff @(posedge clk_i) begin
        if (reset_n_i && !clr_v_i) begin
            assert (!(io.issue_yumi_i && !issue_v))
                else $error("issue_yumi_i asserted while issue_v_o is low");
            assert (!(commit_v_i && (cptr_q == rptr_q)))
                else $error("commit_v_i asserted with no issued entry outstanding");
        end
        assert (is_pow2(els_p)) else $error("els_p must be a power of 2 and >= 2");
        assert (vaddr_width_p == vaddr_width_gp) else $error("vaddr_width_p must match package");
    end

endmodule

// File: tb/tb_bp_be_issue_queue.sv
// Directed self-checking bench for bp_be_issue_queue: fill, replay, clear, wrap, reset.
module tb_bp_be_issue_queue;
    import bp_be_issue_queue_pkg::*;

    logic clk_i = 1'b0;
    logic reset_n_i;
    logic commit_v_i;
    logic roll_v_i;
    logic clr_v_i;
    logic empty_o;
    int   compared   = 0;
    int   mismatched = 0;

    bp_be_issue_queue_if iq_if ();

    bp_be_issue_queue #(.els_p(8), .vaddr_width_p(39)) dut (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .io         (iq_if),
        .commit_v_i (commit_v_i),
        .roll_v_i   (roll_v_i),
        .clr_v_i    (clr_v_i),
        .empty_o    (empty_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic bp_be_issue_pkt_s make_pkt(input logic [vaddr_width_gp-1:0] pc,
                                                  input logic exc_ni,
                                                  input bp_fe_exception_code_e exc);
        bp_be_issue_pkt_s p;
        p.pc            = pc;
        p.instr         = {16'hA5A5, pc[15:0]};
        p.exc_not_instr = exc_ni;
        p.exc           = exc;
        return p;
    endfunction

    task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic fe_v, input logic [vaddr_width_gp-1:0] pc,
                                  input logic exc_ni, input bp_fe_exception_code_e exc,
                                  input logic yumi, input logic commit,
                                  input logic roll, input logic clr);
        iq_if.fe_v_i             = fe_v;
        iq_if.fe_pc_i            = pc;
        iq_if.fe_instr_i         = {16'hA5A5, pc[15:0]};
        iq_if.fe_exc_not_instr_i = exc_ni;
        iq_if.fe_exc_i           = exc;
        iq_if.issue_yumi_i       = yumi;
        commit_v_i               = commit;
        roll_v_i                 = roll;
        clr_v_i                  = clr;
    endtask

    task automatic idle();
        apply_stimulus(1'b0, '0, 1'b0, e_instr_misaligned, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic enq(input logic [vaddr_width_gp-1:0] pc);
        apply_stimulus(1'b1, pc, 1'b0, e_instr_misaligned, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_fe_ready"}, iq_if.fe_ready_o, 1'b1);
        check_output({tag, "_issue_v"}, iq_if.issue_v_o, 1'b0);
        check_output({tag, "_empty"}, empty_o, 1'b1);
        check_output({tag, "_pkt"}, iq_if.issue_pkt_o, '0);
    endtask

    initial begin
        reset_n_i = 1'b0;
        idle();
        #12;
        check_reset_outputs("reset");
        @(negedge clk_i);
        reset_n_i = 1'b1;
        tick();

        // Fill all eight slots with no issue; no write-to-read bypass.
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(1'b1, 39'(32'h100 + 4 * i), 1'b0, e_instr_misaligned, 1'b0, 1'b0, 1'b0, 1'b0);
            if (i == 0) check_output("no_bypass_issue_v", iq_if.issue_v_o, 1'b0);
            tick();
            if (i == 0) check_output("first_pkt", iq_if.issue_pkt_o, make_pkt(39'h100, 1'b0, e_instr_misaligned));
            if (i < 7) check_output("fill_ready", iq_if.fe_ready_o, 1'b1);
        end
        idle();
        check_output("full_ready", iq_if.fe_ready_o, 1'b0);
        check_output("full_empty", empty_o, 1'b0);
        check_output("full_pc", iq_if.issue_pkt_o.pc, 39'h100);

        // Issue three, commit two, then roll back to replay from the commit pointer.
        for (int i = 0; i < 3; i++) begin
            check_output("issue_order_pc", iq_if.issue_pkt_o.pc, 39'(32'h100 + 4 * i));
            apply_stimulus(1'b0, '0, 1'b0, e_instr_misaligned, 1'b1, 1'b0, 1'b0, 1'b0);
            tick();
        end
        apply_stimulus(1'b0, '0, 1'b0, e_instr_misaligned, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        check_output("commit_frees_slot", iq_if.fe_ready_o, 1'b1);
        tick();
        apply_stimulus(1'b0, '0, 1'b0, e_instr_misaligned, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        idle();
        check_output("roll_pc", iq_if.issue_pkt_o.pc, 39'h108);
        check_output("roll_issue_v", iq_if.issue_v_o, 1'b1);
        check_output("roll_ready", iq_if.fe_ready_o, 1'b1);
        enq(39'h120);
        check_output("one_free_left", iq_if.fe_ready_o, 1'b1);
        enq(39'h124);
        idle();
        check_output("refull_ready", iq_if.fe_ready_o, 1'b0);

        // Roll with same-cycle commit; the concurrent yumi is ignored.
        apply_stimulus(1'b0, '0, 1'b0, e_instr_misaligned, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        apply_stimulus(1'b0, '0, 1'b0, e_instr_misaligned, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        idle();
        check_output("roll_commit_pc", iq_if.issue_pkt_o.pc, 39'h10C);
        check_output("roll_commit_ready", iq_if.fe_ready_o, 1'b1);

        // Leave five resident entries, then clear with a same-cycle enq and yumi.
        apply_stimulus(1'b0, '0, 1'b0, e_instr_misaligned, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        apply_stimulus(1'b0, '0, 1'b0, e_instr_misaligned, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        apply_stimulus(1'b0, '0, 1'b0, e_instr_misaligned, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        idle();
        check_output("pre_clr_empty", empty_o, 1'b0);
        apply_stimulus(1'b1, 39'h500, 1'b0, e_instr_misaligned, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        idle();
        check_reset_outputs("clr");

        // From a clean queue: roll + commit with cptr at 0x100 replays 0x104; enq still lands.
        enq(39'h100);
        enq(39'h104);
        apply_stimulus(1'b0, '0, 1'b0, e_instr_misaligned, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        apply_stimulus(1'b1, 39'h108, 1'b0, e_instr_misaligned, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        idle();
        check_output("roll_commit0_pc", iq_if.issue_pkt_o.pc, 39'h104);
        check_output("roll_commit0_issue_v", iq_if.issue_v_o, 1'b1);
        apply_stimulus(1'b0, '0, 1'b0, e_instr_misaligned, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        check_output("enq_during_roll_pc", iq_if.issue_pkt_o.pc, 39'h108);
        apply_stimulus(1'b0, '0, 1'b0, e_instr_misaligned, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        idle();

        // Full-rate stream across the pointer wrap with one-cycle enq-to-issue latency.
        for (int k = 0; k < 20; k++) begin
            if (k == 0) check_output("stream_start_issue_v", iq_if.issue_v_o, 1'b0);
            if (k >= 1) begin
                check_output("stream_issue_v", iq_if.issue_v_o, 1'b1);
                check_output("stream_pc", iq_if.issue_pkt_o.pc, 39'(32'h200 + 4 * (k - 1)));
            end
            check_output("stream_ready", iq_if.fe_ready_o, 1'b1);
            apply_stimulus(1'b1, 39'(32'h200 + 4 * k), 1'b0, e_instr_misaligned,
                           (k >= 1), (k >= 2), 1'b0, 1'b0);
            tick();
        end
        apply_stimulus(1'b0, '0, 1'b0, e_instr_misaligned, 1'b1, 1'b1, 1'b0, 1'b0);
        check_output("stream_last_pc", iq_if.issue_pkt_o.pc, 39'h24C);
        tick();
        idle();
        check_output("stream_drained_issue_v", iq_if.issue_v_o, 1'b0);
        check_output("stream_resident_empty", empty_o, 1'b0);

        // Exception entry passes through intact; then an async reset mid-stream.
        apply_stimulus(1'b1, 39'h300, 1'b1, e_itlb_miss, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        check_output("exc_issue_v", iq_if.issue_v_o, 1'b1);
        check_output("exc_pkt", iq_if.issue_pkt_o, make_pkt(39'h300, 1'b1, e_itlb_miss));
        apply_stimulus(1'b1, 39'h304, 1'b0, e_instr_misaligned, 1'b1, 1'b0, 1'b0, 1'b0);
        reset_n_i = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        idle();
        @(negedge clk_i);
        reset_n_i = 1'b1;
        tick();
        check_output("post_reset_empty", empty_o, 1'b1);
        enq(39'h400);
        idle();
        check_output("post_reset_pkt", iq_if.issue_pkt_o, make_pkt(39'h400, 1'b0, e_instr_misaligned));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #20000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

endmodule
